// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch debouncer: board clock and debounce
// window, plus the counter-width helper used by each channel.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN (edge-pulse outputs).
package debounce_pkg;

    localparam int CLK_FREQ_HZ     = 50000000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEFAULT_CNT_MAX = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    // Bits needed to hold values 0..cnt_max
    function automatic int cnt_width(input int cnt_max);
        return $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bundle: raw levels in, debounced level and edge pulses out.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN (edge-pulse outputs).
interface switch_debouncer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    // Board / stimulus side: drives raw levels, consumes clean outputs
    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall
    );

    // Debouncer side
    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_rise,
        output sw_fall
    );
endinterface

// File: rtl/switch_debouncer_channel.sv
// Single-bit debounce channel: 2-flop synchroniser, stability counter,
// stable level register and registered edge pulses.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN; when undefined the
// edge registers are not built and rise_o/fall_o are tied low.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    // Two-flop synchroniser; only sync2_q is used downstream
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts it
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        accept   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and accepted level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Pulses align with the cycle in which stable_q takes its new value
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept &  sync2_q;
            fall_q <= accept & ~sync2_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer top: WIDTH independent debounce channels behind the
// switch_debouncer_if bundle.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN (edge-pulse outputs;
// when undefined sw_rise/sw_fall are constant 0).
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic                  clk,
    input  logic                  resetn,
    switch_debouncer_if.slave     sw
);

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .CNT_MAX (CNT_MAX)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .raw_i    (sw.sw_raw[i]),
            .stable_o (stable_w[i]),
            .rise_o   (rise_w[i]),
            .fall_o   (fall_w[i])
        );
    end

    assign sw.sw_stable = stable_w;
    assign sw.sw_rise   = rise_w;
    assign sw.sw_fall   = fall_w;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (CNT_MAX = 4, WIDTH = 2) plus a
// CNT_MAX = 1 single-channel instance. Edge-pulse expectations follow
// SWITCH_DEBOUNCER_EDGE_EN: zero when the macro is undefined.
module tb_switch_debouncer;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    switch_debouncer_if #(.WIDTH(2)) sw_if ();
    switch_debouncer_if #(.WIDTH(1)) sw1_if ();

    switch_debouncer #(
        .WIDTH   (2),
        .CNT_MAX (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sw     (sw_if)
    );

    switch_debouncer #(
        .WIDTH   (1),
        .CNT_MAX (1)
    ) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .sw     (sw1_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] edg(input logic [1:0] v);
        return EDGE_EN ? v : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leave time 1 unit past the last edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st,
                           input logic [1:0] ri, input logic [1:0] fa);
        chk({tag, "_stable"}, sw_if.sw_stable, st);
        chk({tag, "_rise"},   sw_if.sw_rise,   ri);
        chk({tag, "_fall"},   sw_if.sw_fall,   fa);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        resetn        = 1'b0;
        sw_if.sw_raw  = 2'b11;
        sw1_if.sw_raw = 1'b0;

        // Reset held with inputs high: everything stays 0
        tick(2);
        chk_all("reset", 2'b00, 2'b00, 2'b00);

        // Release reset with 11 held: accepted at edge 6
        resetn = 1'b1;
        tick(5);
        chk_all("rst_rel_e5", 2'b00, 2'b00, 2'b00);
        tick(1);
        chk_all("rst_rel_e6", 2'b11, edg(2'b11), 2'b00);
        tick(1);
        chk_all("rst_rel_e7", 2'b11, 2'b00, 2'b00);

        // Release of channel 0: fall pulse at edge 6
        sw_if.sw_raw = 2'b10;
        tick(5);
        chk_all("fall_e5", 2'b11, 2'b00, 2'b00);
        tick(1);
        chk_all("fall_e6", 2'b10, 2'b00, edg(2'b01));
        tick(1);
        chk_all("fall_e7", 2'b10, 2'b00, 2'b00);

        // Clean press on channel 0: rise pulse at edge 6
        sw_if.sw_raw = 2'b11;
        tick(5);
        chk_all("clean_e5", 2'b10, 2'b00, 2'b00);
        tick(1);
        chk_all("clean_e6", 2'b11, edg(2'b01), 2'b00);
        tick(1);
        chk_all("clean_e7", 2'b11, 2'b00, 2'b00);

        // Bring channel 1 low to prepare the bounce test
        sw_if.sw_raw = 2'b01;
        tick(6);
        chk_all("ch1_low_e6", 2'b01, 2'b00, edg(2'b10));
        tick(1);

        // Bounce on channel 1: 1,0,1,0 every two cycles, no acceptance
        for (int k = 0; k < 4; k++) begin
            sw_if.sw_raw[1] = (k % 2 == 0);
            tick(1);
            chk("bounce_stable_a", sw_if.sw_stable, 2'b01);
            tick(1);
            chk("bounce_stable_b", sw_if.sw_stable, 2'b01);
            chk("bounce_rise", sw_if.sw_rise, 2'b00);
        end
        sw_if.sw_raw[1] = 1'b1;
        tick(5);
        chk_all("bounce_e5", 2'b01, 2'b00, 2'b00);
        tick(1);
        chk_all("bounce_e6", 2'b11, edg(2'b10), 2'b00);
        tick(1);
        chk_all("bounce_e7", 2'b11, 2'b00, 2'b00);

        // Reset mid-count: channel 0 counter reaches 2, then reset between edges
        sw_if.sw_raw = 2'b10;
        tick(4);
        chk("midcnt_before", sw_if.sw_stable, 2'b11);
        #2;
        resetn = 1'b0;
        #1;
        chk_all("midcnt_async", 2'b00, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(5);
        chk_all("midcnt_e5", 2'b00, 2'b00, 2'b00);
        tick(1);
        chk_all("midcnt_e6", 2'b10, edg(2'b10), 2'b00);
        tick(1);
        chk_all("midcnt_e7", 2'b10, 2'b00, 2'b00);

        // CNT_MAX = 1: stable follows three edges after the raw change
        sw1_if.sw_raw = 1'b1;
        tick(2);
        chk("cm1_e2_stable", {1'b0, sw1_if.sw_stable}, 2'b00);
        tick(1);
        chk("cm1_e3_stable", {1'b0, sw1_if.sw_stable}, 2'b01);
        chk("cm1_e3_rise",   {1'b0, sw1_if.sw_rise},   {1'b0, EDGE_EN});
        tick(1);
        chk("cm1_e4_rise",   {1'b0, sw1_if.sw_rise},   2'b00);
        sw1_if.sw_raw = 1'b0;
        tick(3);
        chk("cm1_fall_stable", {1'b0, sw1_if.sw_stable}, 2'b00);
        chk("cm1_fall_pulse",  {1'b0, sw1_if.sw_fall},   {1'b0, EDGE_EN});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
